// File: rtl/my_nios_pio_pkg.sv
// Shared definitions for the PIO edge-capture peripheral.
// Holds the Avalon-MM register word addresses, the per-bit edge-mode
// encoding, and helpers that decide whether a bit saw a qualifying edge.
package my_nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;  // debounced input value, RO
  localparam logic [2:0] ADDR_MASK = 3'd2;  // irq_mask, RW
  localparam logic [2:0] ADDR_EDGE = 3'd3;  // edge_capture, write-1-to-clear
  localparam logic [2:0] ADDR_POL  = 3'd4;  // polarity, RW (1 = falling)
  localparam logic [2:0] ADDR_ANY  = 3'd5;  // any_edge, RW (1 = both edges)

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_mode_e;

  // any_edge overrides polarity.
  function automatic edge_mode_e edge_mode(input logic pol, input logic any);
    edge_mode_e mode;
    if (any)      mode = EDGE_ANY;
    else if (pol) mode = EDGE_FALLING;
    else          mode = EDGE_RISING;
    return mode;
  endfunction

  function automatic logic edge_hit(input edge_mode_e mode, input logic prev,
                                    input logic cur);
    logic hit;
    case (mode)
      EDGE_RISING:  hit = ~prev & cur;
      EDGE_FALLING: hit = prev & ~cur;
      default:      hit = prev ^ cur;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/my_nios_pio_irq_multi_if.sv
// Avalon-MM slave bus bundle for the PIO peripheral.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
interface my_nios_pio_irq_multi_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/my_nios_pio_debounce.sv
// One-bit input conditioner: two-flop synchronizer followed by an optional
// stable-count debouncer.
//   clk, reset : clock and synchronous active-high reset
//   din        : asynchronous external input
//   dout       : registered debounced value
// The debounced bit is always a flop (even with DEBOUNCE_CYCLES = 0) so the
// input-to-capture latency is 3 edges, plus DEBOUNCE_CYCLES when enabled.
module my_nios_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1_q, s2_q;
  logic deb_q, deb_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the two synchronizer stages stay distinct.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      deb_q <= deb_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb deb_d = s2_q;
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // The counter runs while s2 disagrees with the debounced bit; once it
      // has sat at DEBOUNCE_CYCLES and s2 still disagrees, the bit flips.
      always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and
        // infers a latch.
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s2_q == deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
          deb_d = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign dout = deb_q;

endmodule

// File: rtl/my_nios_pio_irq_multi.sv
// Multi-bit PIO input peripheral with per-bit edge capture and a level IRQ.
//   clk, reset : clock and synchronous active-high reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port    : WIDTH asynchronous inputs, each synchronized and debounced
//   irq        : OR of (edge_capture & irq_mask)
module my_nios_pio_irq_multi
  import my_nios_pio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_POLARITY  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  my_nios_pio_irq_multi_if.slave  bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;
  logic [WIDTH-1:0] pol_q,  pol_d;
  logic [WIDTH-1:0] any_q,  any_d;
  logic [WIDTH-1:0] edge_evt;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    my_nios_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .dout  (deb[i])
    );
  end

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  // Edges are judged against last cycle's debounced value, so a mode change
  // alone can never create an event.
  always_comb begin
    edge_evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_evt[i] = edge_hit(edge_mode(pol_q[i], any_q[i]), prev_q[i], deb[i]);
    end
  end

  always_comb begin
    mask_d = mask_q;
    pol_d  = pol_q;
    any_d  = any_q;
    cap_d  = cap_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_MASK: mask_d = wd;
        ADDR_EDGE: cap_d  = cap_q & ~wd;
        ADDR_POL:  pol_d  = wd;
        ADDR_ANY:  any_d  = wd;
        default:   ;
      endcase
    end
    // OR-ing events after the clear lets a same-cycle event win.
    cap_d = cap_d | edge_evt;
  end

  // Read data is decoded from address alone; chipselect does not gate it.
  always_comb begin
    rd_d = '0;
    case (bus.address)
      ADDR_DATA: rd_d[WIDTH-1:0] = deb;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = cap_q;
      ADDR_POL:  rd_d[WIDTH-1:0] = pol_q;
      ADDR_ANY:  rd_d[WIDTH-1:0] = any_q;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      pol_q  <= RESET_POLARITY;
      any_q  <= '0;
      rd_q   <= '0;
    end else begin
      prev_q <= deb;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      pol_q  <= pol_d;
      any_q  <= any_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.readdata = rd_q;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_my_nios_pio_irq_multi.sv
// Bench for my_nios_pio_irq_multi: one instance without debounce (dut0) and
// one with DEBOUNCE_CYCLES = 4 (dut4). Register reads go through a scoreboard
// queue: the expected word is pushed when the read is issued and popped when
// the registered readdata appears one cycle later.
module tb_my_nios_pio_irq_multi;
  import my_nios_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0, in4;
  logic       irq0, irq4;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  my_nios_pio_irq_multi_if bus0 ();
  my_nios_pio_irq_multi_if bus4 ();

  my_nios_pio_irq_multi #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .RESET_POLARITY(8'h00)) dut0 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus0),
    .in_port (in0),
    .irq     (irq0)
  );

  my_nios_pio_irq_multi #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .RESET_POLARITY(8'h00)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus4),
    .in_port (in4),
    .irq     (irq4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus4.chipselect = 1'b0; bus4.write_n = 1'b1; bus4.writedata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge.
  task automatic bus_write(input bit d4, input logic [2:0] a, input logic [31:0] d);
    if (d4) begin
      bus4.address = a; bus4.chipselect = 1'b1; bus4.write_n = 1'b0; bus4.writedata = d;
    end else begin
      bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = d;
    end
    @(posedge clk);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input bit d4, input logic [2:0] a, input logic [31:0] exp,
                          input string nm);
    logic [31:0] got, e;
    string       n;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    if (d4) bus4.address = a;
    else    bus0.address = a;
    @(posedge clk);
    @(negedge clk);
    got = d4 ? bus4.readdata : bus0.readdata;
    e   = exp_q.pop_front();
    n   = name_q.pop_front();
    checks++;
    if (got !== e) $display("FAIL %s: readdata=%h expected=%h", n, got, e);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if (bus0.readdata !== 32'h0) $display("FAIL rst_rd0: got=%h expected=0", bus0.readdata);
    else passes++;
    checks++;
    if (irq0 !== 1'b0) $display("FAIL rst_irq0: got=%b expected=0", irq0);
    else passes++;
    checks++;
    if (bus4.readdata !== 32'h0) $display("FAIL rst_rd4: got=%h expected=0", bus4.readdata);
    else passes++;
    checks++;
    if (irq4 !== 1'b0) $display("FAIL rst_irq4: got=%b expected=0", irq4);
    else passes++;
    reset = 1'b0;
    for (int a = 0; a < 8; a++) bus_read(1'b0, 3'(a), 32'h0, $sformatf("rst_reg%0d", a));
    bus_read(1'b1, ADDR_POL, 32'h0, "rst_pol4");
    // Unmapped addresses ignore writes and read 0.
    bus_write(1'b0, 3'd1, 32'hFF);
    bus_write(1'b0, 3'd6, 32'hFF);
    bus_read(1'b0, 3'd1, 32'h0, "unmapped1");
    bus_read(1'b0, 3'd6, 32'h0, "unmapped6");
    bus_read(1'b0, ADDR_MASK, 32'h0, "unmapped_no_alias");
  endtask

  task automatic test_rising();
    bus_write(1'b0, ADDR_MASK, 32'h01);
    in0[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq0 !== 1'b0) $display("FAIL rise_early: irq=%b expected=0", irq0);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq0 !== 1'b1) $display("FAIL rise_3edges: irq=%b expected=1", irq0);
    else passes++;
    bus_read(1'b0, ADDR_EDGE, 32'h01, "rise_capture");
    bus_read(1'b0, ADDR_DATA, 32'h01, "rise_data");
    bus_write(1'b0, ADDR_EDGE, 32'h01);
    checks++;
    if (irq0 !== 1'b0) $display("FAIL rise_clear_irq: irq=%b expected=0", irq0);
    else passes++;
    bus_read(1'b0, ADDR_EDGE, 32'h00, "rise_cleared");
  endtask

  task automatic test_polarity();
    bus_write(1'b0, ADDR_POL, 32'hFFFF_FF02);
    bus_read(1'b0, ADDR_POL, 32'h02, "pol_upper_ignored");
    in0[1] = 1'b1;
    idle(6);
    bus_read(1'b0, ADDR_EDGE, 32'h00, "pol_rise_ignored");
    in0[1] = 1'b0;
    idle(6);
    bus_read(1'b0, ADDR_EDGE, 32'h02, "pol_fall_capture");
    checks++;
    if (irq0 !== 1'b0) $display("FAIL pol_masked_irq: irq=%b expected=0", irq0);
    else passes++;
    bus_write(1'b0, ADDR_MASK, 32'h03);
    checks++;
    if (irq0 !== 1'b1) $display("FAIL unmask_irq: irq=%b expected=1", irq0);
    else passes++;
    bus_write(1'b0, ADDR_EDGE, 32'h02);
    bus_write(1'b0, ADDR_MASK, 32'h01);
    bus_write(1'b0, ADDR_ANY, 32'h04);
    bus_read(1'b0, ADDR_ANY, 32'h04, "any_readback");
    in0[2] = 1'b1;
    idle(6);
    bus_read(1'b0, ADDR_EDGE, 32'h04, "any_rise");
    bus_write(1'b0, ADDR_EDGE, 32'h04);
    bus_read(1'b0, ADDR_EDGE, 32'h00, "any_cleared");
    in0[2] = 1'b0;
    idle(6);
    bus_read(1'b0, ADDR_EDGE, 32'h04, "any_fall");
    bus_write(1'b0, ADDR_EDGE, 32'h04);
    // Mode changes alone must not create events.
    bus_write(1'b0, ADDR_POL, 32'hFF);
    bus_write(1'b0, ADDR_ANY, 32'hFF);
    bus_write(1'b0, ADDR_POL, 32'h00);
    bus_write(1'b0, ADDR_ANY, 32'h00);
    idle(2);
    bus_read(1'b0, ADDR_EDGE, 32'h00, "mode_change_quiet");
  endtask

  task automatic test_clear_race();
    in0[0] = 1'b0;
    idle(6);
    bus_read(1'b0, ADDR_EDGE, 32'h00, "race_pre");
    in0[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_write(1'b0, ADDR_EDGE, 32'h01);  // lands on the capture edge
    bus_read(1'b0, ADDR_EDGE, 32'h01, "race_event_wins");
    checks++;
    if (irq0 !== 1'b1) $display("FAIL race_irq: irq=%b expected=1", irq0);
    else passes++;
    bus_write(1'b0, ADDR_EDGE, 32'hFE);
    bus_read(1'b0, ADDR_EDGE, 32'h01, "clear_fe_keeps_bit0");
    bus_write(1'b0, ADDR_EDGE, 32'h01);
    bus_read(1'b0, ADDR_EDGE, 32'h00, "race_cleared");
  endtask

  task automatic test_debounce();
    bus_write(1'b1, ADDR_MASK, 32'h08);
    in4[3] = 1'b1;
    idle(3);
    in4[3] = 1'b0;
    idle(12);
    bus_read(1'b1, ADDR_DATA, 32'h00, "glitch_data");
    bus_read(1'b1, ADDR_EDGE, 32'h00, "glitch_capture");
    checks++;
    if (irq4 !== 1'b0) $display("FAIL glitch_irq: irq=%b expected=0", irq4);
    else passes++;
    in4[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) in4[3] = 1'b0;
      if (k == 7) begin
        checks++;
        if (irq4 !== 1'b0) $display("FAIL deb_early: irq=%b expected=0", irq4);
        else passes++;
      end
      if (k == 8) begin
        checks++;
        if (irq4 !== 1'b1) $display("FAIL deb_7edges: irq=%b expected=1", irq4);
        else passes++;
      end
    end
    bus_read(1'b1, ADDR_DATA, 32'h08, "deb_data_high");
    idle(10);
    bus_read(1'b1, ADDR_DATA, 32'h00, "deb_data_low");
    bus_read(1'b1, ADDR_EDGE, 32'h08, "deb_capture_kept");
  endtask

  task automatic test_reset_mid();
    bus_write(1'b1, ADDR_MASK, 32'hFF);
    bus_write(1'b1, ADDR_ANY, 32'hFF);
    in4 = 8'hFF;
    idle(12);
    bus_read(1'b1, ADDR_EDGE, 32'hFF, "pre_reset_capture");
    checks++;
    if (irq4 !== 1'b1) $display("FAIL pre_reset_irq: irq=%b expected=1", irq4);
    else passes++;
    in4 = 8'hDF;
    idle(4);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq4 !== 1'b0) $display("FAIL midrst_irq: irq=%b expected=0", irq4);
    else passes++;
    checks++;
    if (bus4.readdata !== 32'h0) $display("FAIL midrst_rd: readdata=%h expected=0", bus4.readdata);
    else passes++;
    reset = 1'b0;
    bus_read(1'b1, ADDR_DATA, 32'h00, "midrst_data");
    bus_read(1'b1, ADDR_EDGE, 32'h00, "midrst_capture");
    bus_read(1'b1, ADDR_MASK, 32'h00, "midrst_mask");
    bus_read(1'b1, ADDR_ANY,  32'h00, "midrst_any");
    bus_read(1'b1, ADDR_POL,  32'h00, "midrst_pol");
    in4 = 8'h00;
  endtask

  initial begin
    bus_idle();
    bus0.address = '0;
    bus4.address = '0;
    in0   = '0;
    in4   = '0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_rising();
    test_polarity();
    test_clear_race();
    test_debounce();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/my_nios_pio_irq_multi.md
MY_NIOS_PIO_IRQ_MULTI -- requirements
Module: my_nios_pio_irq_multi

Interface
REQ-001 Parameter WIDTH, default 8, number of input bits (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 0, stable-cycle count required per bit; 0 bypasses debounce.
REQ-003 Parameter RESET_POLARITY, default 0, reset value of the polarity register (WIDTH bits).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  3  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 readdata  output  32  registered read data; bits above WIDTH-1 read 0.
REQ-013 irq  output  WIDTH>0 ? 1 : 1  level interrupt, OR of (edge_capture AND irq_mask).

Function
REQ-014 Map: 0 data (RO, debounced value); 2 irq_mask (RW); 3 edge_capture (write-1-to-clear); 4 polarity (RW; 1 = falling edge); 5 any_edge (RW; 1 = both edges, overrides polarity); 1, 6, 7 read 0, writes ignored.
REQ-015 readdata SHALL be registered every cycle from address (no chipselect qualification), one-cycle read latency.
REQ-016 Write occurs when chipselect=1 and write_n=0; it takes effect on that clock edge.
REQ-017 Each in_port bit SHALL pass a two-flop synchronizer (s1, s2) before any other use.
REQ-018 DEBOUNCE_CYCLES=0: debounced bit = s2.
REQ-019 DEBOUNCE_CYCLES=N>0: per-bit counter clears whenever s2 equals the debounced bit, otherwise increments; when it reaches N the debounced bit takes s2 and the counter clears.
REQ-020 A glitch shorter than N cycles SHALL NOT change the debounced bit nor set edge_capture.
REQ-021 Edge event per bit: any_edge=1 -> debounced bit changed; else polarity=0 -> 0-to-1; polarity=1 -> 1-to-0; comparison against the debounced value registered one cycle earlier.
REQ-022 Edge event SHALL set the corresponding edge_capture bit on the following clock edge; bit stays set until cleared.
REQ-023 With DEBOUNCE_CYCLES=0, edge_capture bit SHALL be set 3 clk edges after the edge at which in_port change is first sampled; each debounce cycle adds N.
REQ-024 Write to address 3 SHALL clear exactly the bits with writedata=1; others unchanged.
REQ-025 Simultaneous clear and edge event on the same bit: bit SHALL remain set (event wins).
REQ-026 Changing polarity/any_edge SHALL NOT itself generate an event; edge_capture unchanged.
REQ-027 irq combinational from edge_capture and irq_mask; unmasking a set capture bit asserts irq the cycle after the mask write.

Reset
REQ-028 On reset: readdata=0, irq_mask=0, edge_capture=0, any_edge=0, polarity=RESET_POLARITY, synchronizers, debounced bits, previous-value bits and counters =0; irq=0.
REQ-029 Reset mid-debounce SHALL discard the count; no edge event in the cycle after reset deasserts even if in_port=1 (the next event requires a new transition through the pipeline).

Structure
REQ-030 Package my_nios_pio_pkg SHALL hold address constants (ADDR_DATA, ADDR_MASK, ADDR_EDGE, ADDR_POL, ADDR_ANY) and edge-mode encoding.
REQ-031 Per-bit sync+debounce SHALL be sub-module my_nios_pio_debounce (one bit, DEBOUNCE_CYCLES parameter), instantiated WIDTH times via generate.

Verification
REQ-032 WIDTH=8, N=0, mask=0x01, in_port bit0 0->1 -> edge_capture=0x01 3 edges later, irq=1; write 0x01 to addr 3 -> capture=0, irq=0.
REQ-033 polarity=0x02, bit1 1->0 -> capture=0x02; bit1 0->1 -> no change; any_edge=0x04, bit2 toggled twice -> capture bit2 set, cleared, set again.
REQ-034 N=4, 3-cycle pulse on bit3 -> data and capture unchanged; 6-cycle pulse -> capture bit3 set 2+4+1 edges after sampling.
REQ-035 Clear write to addr 3 in same cycle as bit0 event -> capture bit0 remains 1; clear of 0xFE leaves bit0 intact.
REQ-036 Assert reset while bit5 mid-debounce with capture=0xFF, mask=0xFF -> next cycle all registers 0, irq=0, readdata=0.
